// File: rtl/flash_boot_loader.sv
// Boot loader: reads NUM_WORDS serial flash words and writes each one to SRAM as WORD_W/SRAM_DW beats.
// Latency: 2*CLK_DIV*WORD_W clk per word from FETCH entry to word_ready, then WORD_W/SRAM_DW write cycles.
// Backpressure: none; flash and SRAM are free-running slaves. start is honoured only in IDLE or DONE.
module flash_boot_loader #(
  parameter int WORD_W    = 32,
  parameter int SRAM_DW   = 8,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 4,
  parameter int CLK_DIV   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               flash_miso,
  output logic               flash_clk,
  output logic               flash_cs_n,
  output logic               fetch_en,
  output logic               word_ready,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [SRAM_DW-1:0] sram_data,
  output logic               busy,
  output logic               done
);

  localparam int BEATS  = WORD_W / SRAM_DW;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCNT_W = $clog2(NUM_WORDS + 1);

  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(WORD_W - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BEATS - 1);
  localparam logic [WCNT_W-1:0] WORDS    = WCNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic [BEAT_W-1:0] r_beat;
  logic [WCNT_W-1:0] r_word_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-2:0] r_shift;
  logic [WORD_W-1:0] r_word;

  logic [WORD_W-1:0]  w_full_word;
  logic [SRAM_DW-1:0] w_next_slice;
  int                 w_slice_idx;

  // The bit arriving on this falling edge completes the shift register contents.
  assign w_full_word = {r_shift, flash_miso};

  // Select the slice for the beat after the current one, most-significant slice first.
  always_comb begin
    w_slice_idx = BEATS - 2 - int'(r_beat);
    if (w_slice_idx < 0) begin
      w_slice_idx = 0;
    end
    w_next_slice = r_word[w_slice_idx*SRAM_DW +: SRAM_DW];
  end

  // Boot-load FSM: divider, serial capture, beat writer and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_beat     <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
      r_shift    <= '0;
      r_word     <= '0;
      flash_clk  <= 1'b0;
      flash_cs_n <= 1'b1;
      fetch_en   <= 1'b0;
      word_ready <= 1'b0;
      sram_cen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_addr  <= '0;
      sram_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FETCH;
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_div      <= '0;
            r_bit      <= '0;
            flash_clk  <= 1'b0;
            flash_cs_n <= 1'b0;
            fetch_en   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end

        FETCH: begin
          if (r_div == DIV_MAX) begin
            r_div <= '0;
            if (flash_clk) begin
              // Falling edge of flash_clk: the flash data has been stable since the rise.
              flash_clk <= 1'b0;
              if (r_bit == BIT_MAX) begin
                // Word complete: latch it and issue the first beat on the same edge.
                r_bit      <= '0;
                r_word     <= w_full_word;
                r_word_cnt <= r_word_cnt + 1'b1;
                word_ready <= 1'b1;
                fetch_en   <= 1'b0;
                state      <= WRITE;
                r_beat     <= '0;
                sram_cen   <= 1'b0;
                sram_wen   <= 1'b0;
                sram_addr  <= r_addr;
                sram_data  <= w_full_word[WORD_W-1 -: SRAM_DW];
                r_addr     <= r_addr + 1'b1;
              end else begin
                r_shift <= w_full_word[WORD_W-2:0];
                r_bit   <= r_bit + 1'b1;
              end
            end else begin
              flash_clk <= 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        WRITE: begin
          if (r_beat == BEAT_MAX) begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            if (r_word_cnt < WORDS) begin
              // More words to go: chip select stays low, divider restarts.
              state    <= FETCH;
              fetch_en <= 1'b1;
              r_div    <= '0;
              r_bit    <= '0;
            end else begin
              state      <= DONE;
              flash_cs_n <= 1'b1;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end else begin
            r_beat    <= r_beat + 1'b1;
            sram_addr <= r_addr;
            sram_data <= w_next_slice;
            r_addr    <= r_addr + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
